// File: rtl/axis_rr_packet_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rr_packet_arbiter
//
// Purpose:
//   Shares one AXI-Stream output channel between NUM_IN input streams.
//   Arbitration is round-robin at packet granularity. Once an input is granted,
//   it keeps the output until its tlast beat has been accepted. Each
//   arbitration decision costs one IDLE cycle. During that cycle no input is
//   ready. The output is a single full-throughput register stage. The granted
//   input can therefore stream one beat per cycle while the downstream drains
//   the held beat.
//
// Ports:
//   aclk           in   clock, all logic on the rising edge
//   areset         in   synchronous active-high reset
//   s_axis_tdata   in   NUM_IN*DATA_W, input i at [i*DATA_W +: DATA_W]
//   s_axis_tvalid  in   NUM_IN, per-input VALID
//   s_axis_tlast   in   NUM_IN, per-input LAST
//   s_axis_tready  out  NUM_IN, per-input READY (only the granted bit can rise)
//   m_axis_tdata   out  DATA_W, registered output data
//   m_axis_tvalid  out  registered output VALID
//   m_axis_tlast   out  registered output LAST
//   m_axis_tid     out  ID_W, index of the input that produced the beat
//   m_axis_tready  in   downstream READY
// -----------------------------------------------------------------------------
module axis_rr_packet_arbiter #(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 8,
    parameter int ID_W   = 2
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [NUM_IN*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_IN-1:0]        s_axis_tvalid,
    input  logic [NUM_IN-1:0]        s_axis_tlast,
    output logic [NUM_IN-1:0]        s_axis_tready,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    output logic [ID_W-1:0]          m_axis_tid,
    input  logic                     m_axis_tready
);

    // Width of an index into the NUM_IN-wide vectors. ID_W may be wider.
    localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [ID_W-1:0]     grant_r;
    logic [ID_W-1:0]     grant_next_s;
    logic [ID_W-1:0]     last_grant_r;
    logic [ID_W-1:0]     last_grant_next_s;

    logic [DATA_W-1:0]   out_data_r;
    logic [DATA_W-1:0]   out_data_next_s;
    logic                out_valid_r;
    logic                out_valid_next_s;
    logic                out_last_r;
    logic                out_last_next_s;
    logic [ID_W-1:0]     out_tid_r;
    logic [ID_W-1:0]     out_tid_next_s;

    logic [SEL_W-1:0]    grant_sel_s;
    logic                slot_free_s;
    logic                accept_s;
    logic [DATA_W-1:0]   beat_data_s;
    logic                beat_last_s;
    logic                pick_valid_s;
    logic [ID_W-1:0]     pick_idx_s;
    logic [NUM_IN-1:0]   ready_s;

    // The grant is kept in ID_W bits. Only the low SEL_W bits address inputs.
    assign grant_sel_s = grant_r[SEL_W-1:0];

    // The output register can take a new beat when it is empty or draining now.
    assign slot_free_s = !out_valid_r || m_axis_tready;

    // This is the handshake on the granted input. It is qualified by state, so
    // a stale grant held in IDLE never accepts a beat.
    assign accept_s    = (state_r == ST_BUSY) && s_axis_tvalid[grant_sel_s] && slot_free_s;
    assign beat_data_s = s_axis_tdata[int'(grant_sel_s) * DATA_W +: DATA_W];
    assign beat_last_s = s_axis_tlast[grant_sel_s];

    // Round-robin pick: first requester scanning upward from last_grant+1, wrapping
    always_comb begin
        int cand_v;
        logic hit_v;
        cand_v       = 0;
        hit_v        = 1'b0;
        pick_valid_s = 1'b0;
        pick_idx_s   = '0;
        for (int off = 1; off <= NUM_IN; off++) begin
            cand_v       = (int'(last_grant_r) + off) % NUM_IN;
            hit_v        = !pick_valid_s && s_axis_tvalid[SEL_W'(cand_v)];
            pick_idx_s   = hit_v ? ID_W'(cand_v) : pick_idx_s;
            pick_valid_s = pick_valid_s | hit_v;
        end
    end

    // READY fan-out: only the granted input, only when BUSY and the slot is free.
    // It never looks at s_axis_tvalid, so it cannot form a loop with upstream.
    always_comb begin
        ready_s = '0;
        if (!areset && (state_r == ST_BUSY)) begin
            ready_s[grant_sel_s] = slot_free_s;
        end else begin
            ready_s = '0;
        end
    end

    assign s_axis_tready = ready_s;

    // Next-state logic for the IDLE/BUSY packet arbiter
    always_comb begin
        state_next_s      = state_r;
        grant_next_s      = grant_r;
        last_grant_next_s = last_grant_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_next_s = ST_BUSY;
                    grant_next_s = pick_idx_s;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // A source stalling mid-packet simply holds the grant. There is
                // no timeout.
                if (accept_s && beat_last_s) begin
                    last_grant_next_s = grant_r;
                    state_next_s      = ST_IDLE;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Next value of the output register: load on accept, clear on drain, else hold
    always_comb begin
        out_data_next_s  = out_data_r;
        out_valid_next_s = out_valid_r;
        out_last_next_s  = out_last_r;
        out_tid_next_s   = out_tid_r;
        if (accept_s) begin
            // A drain in the same cycle is covered: the new beat replaces the old.
            out_data_next_s  = beat_data_s;
            out_last_next_s  = beat_last_s;
            out_tid_next_s   = grant_r;
            out_valid_next_s = 1'b1;
        end else if (m_axis_tready) begin
            out_valid_next_s = 1'b0;
        end else begin
            out_valid_next_s = out_valid_r;
        end
    end

    // Arbiter state registers. Reset gives input 0 first priority.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            last_grant_r <= ID_W'(NUM_IN - 1);
        end else begin
            state_r      <= state_next_s;
            grant_r      <= grant_next_s;
            last_grant_r <= last_grant_next_s;
        end
    end

    // Output register stage. Reset drops any held beat.
    always_ff @(posedge aclk) begin
        if (areset) begin
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_tid_r   <= '0;
        end else begin
            out_data_r  <= out_data_next_s;
            out_valid_r <= out_valid_next_s;
            out_last_r  <= out_last_next_s;
            out_tid_r   <= out_tid_next_s;
        end
    end

    assign m_axis_tdata  = out_data_r;
    assign m_axis_tvalid = out_valid_r;
    assign m_axis_tlast  = out_last_r;
    assign m_axis_tid    = out_tid_r;

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axis_rr_packet_arbiter
//
// Self-checking bench for axis_rr_packet_arbiter with 4 inputs of 8 bits.
// Each input has a queue of {tlast, tdata} beats to send. A transaction-level
// reference model tracks these quantities with plain integers:
//   - which input currently owns the output (-1 means an arbitration cycle)
//   - the last input to finish a packet
//   - the beat that should be visible on the output
// Each cycle, the bench compares s_axis_tready and every m_axis_* field
// against that model. The scenario tasks also compare the transferred output
// stream against fixed expected sequences.
// -----------------------------------------------------------------------------
module tb_axis_rr_packet_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic            aclk = 1'b0;
    logic            areset;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tlast;
    logic [IW-1:0]   m_tid;
    logic            m_tready;

    always #5 aclk = ~aclk;

    axis_rr_packet_arbiter #(.NUM_IN(N), .DATA_W(DW), .ID_W(IW)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tid    (m_tid),
        .m_axis_tready (m_tready)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Per-input beats still to send: {tlast, tdata}
    logic [8:0]  srcq [N][$];
    bit          stall [N];

    // Reference model state
    int          mdl_owner = -1;
    int          mdl_last  = N - 1;
    bit          mdl_valid = 1'b0;
    logic [7:0]  mdl_data  = 8'h00;
    bit          mdl_tlast = 1'b0;
    int          mdl_tid   = 0;

    // Beats seen crossing the output handshake: {tid, tlast, tdata}
    logic [10:0] dut_log [$];

    task automatic drive_inputs();
        bit v;
        for (int i = 0; i < N; i++) begin
            v = (srcq[i].size() > 0) && !stall[i];
            s_tvalid[i] = v;
            if (v) begin
                s_tdata[i*DW +: DW] = srcq[i][0][7:0];
                s_tlast[i]          = srcq[i][0][8];
            end else begin
                // Junk on idle lanes: the DUT may only sample on a handshake
                s_tdata[i*DW +: DW] = 8'($urandom);
                s_tlast[i]          = 1'($urandom);
            end
        end
    endtask

    function automatic bit pending();
        bit p;
        p = mdl_valid || (mdl_owner >= 0);
        for (int i = 0; i < N; i++) p = p || (srcq[i].size() > 0);
        return p;
    endfunction

    // One clock cycle: drive, check READY, clock, advance model, check outputs
    task automatic tick();
        logic [N-1:0] exp_rdy;
        bit           free;
        bit           acc;
        logic [7:0]   d;
        bit           l;
        drive_inputs();
        #1;
        free    = !mdl_valid || m_tready;
        exp_rdy = '0;
        acc     = 1'b0;
        d       = 8'h00;
        l       = 1'b0;
        if (!areset && mdl_owner >= 0 && free) exp_rdy[mdl_owner] = 1'b1;
        vectors++;
        if (s_tready !== exp_rdy) begin
            miscompares++;
            $display("FAIL tready at %0t: got %b expected %b", $time, s_tready, exp_rdy);
        end
        if (!areset && mdl_owner >= 0 && free && s_tvalid[mdl_owner]) begin
            acc = 1'b1;
            d   = s_tdata[mdl_owner*DW +: DW];
            l   = s_tlast[mdl_owner];
        end
        if (!areset && m_tvalid === 1'b1 && m_tready) dut_log.push_back({m_tid, m_tlast, m_tdata});
        @(posedge aclk);
        if (areset) begin
            mdl_owner = -1;
            mdl_last  = N - 1;
            mdl_valid = 1'b0;
            mdl_data  = 8'h00;
            mdl_tlast = 1'b0;
            mdl_tid   = 0;
        end else if (acc) begin
            mdl_valid = 1'b1;
            mdl_data  = d;
            mdl_tlast = l;
            mdl_tid   = mdl_owner;
            void'(srcq[mdl_owner].pop_front());
            if (l) begin
                mdl_last  = mdl_owner;
                mdl_owner = -1;
            end
        end else begin
            if (mdl_valid && m_tready) mdl_valid = 1'b0;
            if (mdl_owner < 0) begin
                for (int k = 1; k <= N; k++) begin
                    if (mdl_owner < 0 && s_tvalid[(mdl_last + k) % N]) mdl_owner = (mdl_last + k) % N;
                end
            end
        end
        #1;
        vectors++;
        if (m_tvalid !== mdl_valid || m_tdata !== mdl_data || m_tlast !== mdl_tlast || m_tid !== 2'(mdl_tid)) begin
            miscompares++;
            $display("FAIL output at %0t: got v=%b d=%h l=%b id=%0d expected v=%b d=%h l=%b id=%0d",
                     $time, m_tvalid, m_tdata, m_tlast, m_tid, mdl_valid, mdl_data, mdl_tlast, mdl_tid);
        end
    endtask

    task automatic apply_reset();
        areset = 1'b1;
        for (int i = 0; i < N; i++) stall[i] = 1'b0;
        tick();
        tick();
        areset = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        m_tready = 1'b1;
        while (pending() && n < max_cycles) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= max_cycles) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d cycles expected < %0d", n, max_cycles);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) srcq[i].push_back({1'b1, 8'($urandom)});
        m_tready = 1'b1;
        apply_reset();
        vectors++;
        if (m_tvalid !== 1'b0 || m_tdata !== 8'h00 || m_tlast !== 1'b0 || m_tid !== 2'd0 || s_tready !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b d=%h l=%b id=%0d rdy=%b expected all zero",
                     m_tvalid, m_tdata, m_tlast, m_tid, s_tready);
        end
        for (int i = 0; i < N; i++) srcq[i].delete();
        tick();
    endtask

    task automatic test_single();
        logic [10:0] exp [3];
        exp[0] = {2'd0, 1'b0, 8'h11};
        exp[1] = {2'd0, 1'b0, 8'h22};
        exp[2] = {2'd0, 1'b1, 8'h33};
        apply_reset();
        dut_log.delete();
        m_tready = 1'b1;
        srcq[0].push_back({1'b0, 8'h11});
        srcq[0].push_back({1'b0, 8'h22});
        srcq[0].push_back({1'b1, 8'h33});
        tick();
        vectors++;
        if (m_tvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_idle_cycle: got tvalid=%b expected 0", m_tvalid);
        end
        drain(20);
        vectors++;
        if (dut_log.size() != 3) begin
            miscompares++;
            $display("FAIL single_count: got %0d expected 3", dut_log.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (dut_log[k] !== exp[k]) begin
                    miscompares++;
                    $display("FAIL single_beat%0d: got %h expected %h", k, dut_log[k], exp[k]);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [10:0] e;
        apply_reset();
        dut_log.delete();
        m_tready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < N; i++) begin
                srcq[i].push_back({1'b0, 4'(i), 4'h0});
                srcq[i].push_back({1'b1, 4'(i), 4'h1});
            end
        end
        drain(200);
        vectors++;
        if (dut_log.size() != 24) begin
            miscompares++;
            $display("FAIL rr_count: got %0d expected 24", dut_log.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                e = {2'((k / 2) % N), 1'(k % 2), 4'((k / 2) % N), 4'(k % 2)};
                vectors++;
                if (dut_log[k] !== e) begin
                    miscompares++;
                    $display("FAIL rr_beat%0d: got %h expected %h", k, dut_log[k], e);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        apply_reset();
        dut_log.delete();
        m_tready = 1'b1;
        srcq[2].push_back({1'b0, 8'hA5});
        srcq[2].push_back({1'b1, 8'h5A});
        n = 0;
        while (m_tvalid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 10) begin
            miscompares++;
            $display("FAIL bp_first_beat: got no tvalid in %0d cycles expected within 10", n);
        end
        m_tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++;
            if (m_tvalid !== 1'b1 || m_tdata !== 8'hA5 || s_tready[2] !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got v=%b d=%h rdy2=%b expected v=1 d=a5 rdy2=0",
                         c, m_tvalid, m_tdata, s_tready[2]);
            end
        end
        drain(20);
        vectors++;
        if (dut_log.size() != 2 || dut_log[0] !== {2'd2, 1'b0, 8'hA5} || dut_log[1] !== {2'd2, 1'b1, 8'h5A}) begin
            miscompares++;
            $display("FAIL bp_stream: got %0d beats (%h %h) expected 2 beats (4a5 55a)",
                     dut_log.size(), (dut_log.size() > 0) ? dut_log[0] : 11'h0,
                     (dut_log.size() > 1) ? dut_log[1] : 11'h0);
        end
    endtask

    task automatic test_source_stall();
        int n;
        logic [1:0] exp_id [6];
        exp_id = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3};
        apply_reset();
        dut_log.delete();
        m_tready = 1'b1;
        for (int b = 0; b < 4; b++) srcq[1].push_back({(b == 3) ? 1'b1 : 1'b0, 8'h10 + 8'(b)});
        n = 0;
        while (srcq[1].size() > 3 && n < 10) begin
            tick();
            n++;
        end
        srcq[3].push_back({1'b0, 8'h30});
        srcq[3].push_back({1'b1, 8'h31});
        stall[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (s_tready[3] !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_rdy3_%0d: got %b expected 0", c, s_tready[3]);
            end
        end
        stall[1] = 1'b0;
        drain(40);
        vectors++;
        if (dut_log.size() != 6) begin
            miscompares++;
            $display("FAIL stall_count: got %0d expected 6", dut_log.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                vectors++;
                if (dut_log[k][10:9] !== exp_id[k]) begin
                    miscompares++;
                    $display("FAIL stall_id%0d: got %0d expected %0d", k, dut_log[k][10:9], exp_id[k]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        m_tready = 1'b1;
        srcq[3].push_back({1'b1, 8'h3F});
        drain(20);
        dut_log.delete();
        srcq[2].push_back({1'b1, 8'h2F});
        srcq[0].push_back({1'b1, 8'h0F});
        drain(20);
        vectors++;
        if (dut_log.size() != 2 || dut_log[0] !== {2'd0, 1'b1, 8'h0F} || dut_log[1] !== {2'd2, 1'b1, 8'h2F}) begin
            miscompares++;
            $display("FAIL wrap_order: got %0d beats first=%h expected 0 then 2",
                     dut_log.size(), (dut_log.size() > 0) ? dut_log[0] : 11'h0);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        apply_reset();
        m_tready = 1'b1;
        for (int b = 0; b < 4; b++) srcq[1].push_back({(b == 3) ? 1'b1 : 1'b0, 8'hB0 + 8'(b)});
        n = 0;
        while (srcq[1].size() > 2 && n < 10) begin
            tick();
            n++;
        end
        areset = 1'b1;
        tick();
        areset = 1'b0;
        srcq[1].delete();
        vectors++;
        if (m_tvalid !== 1'b0 || s_tready !== 4'b0000) begin
            miscompares++;
            $display("FAIL midreset_state: got v=%b rdy=%b expected v=0 rdy=0000", m_tvalid, s_tready);
        end
        dut_log.delete();
        srcq[1].push_back({1'b1, 8'h1A});
        srcq[0].push_back({1'b1, 8'h0A});
        drain(20);
        vectors++;
        if (dut_log.size() != 2 || dut_log[0] !== {2'd0, 1'b1, 8'h0A} || dut_log[1] !== {2'd1, 1'b1, 8'h1A}) begin
            miscompares++;
            $display("FAIL midreset_priority: got %0d beats first=%h expected 0 then 1",
                     dut_log.size(), (dut_log.size() > 0) ? dut_log[0] : 11'h0);
        end
    endtask

    task automatic test_random();
        int total;
        int len;
        apply_reset();
        dut_log.delete();
        total = 0;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < N; i++) begin
                len = int'($urandom_range(1, 4));
                for (int b = 0; b < len; b++) srcq[i].push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
                total += len;
            end
        end
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) stall[i] = ($urandom_range(0, 3) == 0);
            m_tready = ($urandom_range(0, 9) < 7);
            tick();
        end
        for (int i = 0; i < N; i++) stall[i] = 1'b0;
        drain(400);
        vectors++;
        if (dut_log.size() != total) begin
            miscompares++;
            $display("FAIL random_conservation: got %0d beats expected %0d", dut_log.size(), total);
        end
    endtask

    initial begin
        areset   = 1'b1;
        m_tready = 1'b1;
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        for (int i = 0; i < N; i++) stall[i] = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_source_stall();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
